// File: rtl/fft4_cplx_stream.sv
// 4-point radix-2 DIT FFT on complex samples: one frame in flight, two registered
// butterfly stages, valid/ready on both sides with output back-pressure.
module fft4_cplx_stream #(
    parameter int WIDTH = 16,
    parameter int SCALE = 1,
    localparam int OW = (SCALE != 0) ? WIDTH : WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x0_re,
    input  logic signed [WIDTH-1:0] x1_re,
    input  logic signed [WIDTH-1:0] x2_re,
    input  logic signed [WIDTH-1:0] x3_re,
    input  logic signed [WIDTH-1:0] x0_im,
    input  logic signed [WIDTH-1:0] x1_im,
    input  logic signed [WIDTH-1:0] x2_im,
    input  logic signed [WIDTH-1:0] x3_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OW-1:0]    X0_re,
    output logic signed [OW-1:0]    X1_re,
    output logic signed [OW-1:0]    X2_re,
    output logic signed [OW-1:0]    X3_re,
    output logic signed [OW-1:0]    X0_im,
    output logic signed [OW-1:0]    X1_im,
    output logic signed [OW-1:0]    X2_im,
    output logic signed [OW-1:0]    X3_im,
    output logic                    busy
);

    localparam int S1W = (SCALE != 0) ? WIDTH : WIDTH + 1;

    typedef enum logic [1:0] {IDLE, S1, S2, OUT} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] xr_p0 [4];
    logic signed [WIDTH-1:0] xi_p0 [4];
    logic signed [S1W-1:0]   ar_p1 [4];
    logic signed [S1W-1:0]   ai_p1 [4];
    logic signed [OW-1:0]    Xr_p2 [4];
    logic signed [OW-1:0]    Xi_p2 [4];

    // Add/sub at one extra bit; with scaling, floor-halve back to the input width.
    function automatic logic signed [S1W-1:0] bfly1(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b,
                                                    input logic sub);
        logic signed [WIDTH:0] ea, eb, s;
        ea = a;
        eb = b;
        s  = sub ? ea - eb : ea + eb;
        if (SCALE != 0) return S1W'(s >>> 1);
        else            return S1W'(s);
    endfunction

    function automatic logic signed [OW-1:0] bfly2(input logic signed [S1W-1:0] a,
                                                   input logic signed [S1W-1:0] b,
                                                   input logic sub);
        logic signed [S1W:0] ea, eb, s;
        ea = a;
        eb = b;
        s  = sub ? ea - eb : ea + eb;
        if (SCALE != 0) return OW'(s >>> 1);
        else            return OW'(s);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S1;
            end
            S1:  state_nxt = S2;
            S2:  state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage 0: capture the accepted frame
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            xr_p0[0] <= x0_re;  xi_p0[0] <= x0_im;
            xr_p0[1] <= x1_re;  xi_p0[1] <= x1_im;
            xr_p0[2] <= x2_re;  xi_p0[2] <= x2_im;
            xr_p0[3] <= x3_re;  xi_p0[3] <= x3_im;
        end
    end

    // stage 1: even/odd pair butterflies
    always_ff @(posedge clk) begin
        if (state == S1) begin
            ar_p1[0] <= bfly1(xr_p0[0], xr_p0[2], 1'b0);
            ai_p1[0] <= bfly1(xi_p0[0], xi_p0[2], 1'b0);
            ar_p1[1] <= bfly1(xr_p0[0], xr_p0[2], 1'b1);
            ai_p1[1] <= bfly1(xi_p0[0], xi_p0[2], 1'b1);
            ar_p1[2] <= bfly1(xr_p0[1], xr_p0[3], 1'b0);
            ai_p1[2] <= bfly1(xi_p0[1], xi_p0[3], 1'b0);
            ar_p1[3] <= bfly1(xr_p0[1], xr_p0[3], 1'b1);
            ai_p1[3] <= bfly1(xi_p0[1], xi_p0[3], 1'b1);
        end
    end

    // stage 2: (-j)*a3 = a3_im - j*a3_re, folded into the add/sub operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                Xr_p2[k] <= '0;
                Xi_p2[k] <= '0;
            end
        end else if (state == S2) begin
            Xr_p2[0] <= bfly2(ar_p1[0], ar_p1[2], 1'b0);
            Xi_p2[0] <= bfly2(ai_p1[0], ai_p1[2], 1'b0);
            Xr_p2[2] <= bfly2(ar_p1[0], ar_p1[2], 1'b1);
            Xi_p2[2] <= bfly2(ai_p1[0], ai_p1[2], 1'b1);
            Xr_p2[1] <= bfly2(ar_p1[1], ai_p1[3], 1'b0);
            Xi_p2[1] <= bfly2(ai_p1[1], ar_p1[3], 1'b1);
            Xr_p2[3] <= bfly2(ar_p1[1], ai_p1[3], 1'b1);
            Xi_p2[3] <= bfly2(ai_p1[1], ar_p1[3], 1'b0);
        end
    end

    assign X0_re = Xr_p2[0];
    assign X1_re = Xr_p2[1];
    assign X2_re = Xr_p2[2];
    assign X3_re = Xr_p2[3];
    assign X0_im = Xi_p2[0];
    assign X1_im = Xi_p2[1];
    assign X2_im = Xi_p2[2];
    assign X3_im = Xi_p2[3];

endmodule

// File: tb/tb_fft4_cplx_stream.sv
// Scoreboard bench for fft4_cplx_stream: one unscaled (SCALE=0) and one scaled
// (SCALE=1) instance, directed frames with hand-computed spectra.
module tb_fft4_cplx_stream;

    typedef struct {
        int re[4];
        int im[4];
    } frame_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic iv0 = 1'b0, iv1 = 1'b0;
    logic ordy0 = 1'b1, ordy1 = 1'b1;
    logic rdy0, rdy1, ov0, ov1, busy0, busy1;
    logic signed [15:0] xr0 [4];
    logic signed [15:0] xi0 [4];
    logic signed [15:0] xr1 [4];
    logic signed [15:0] xi1 [4];
    logic signed [17:0] Xr0 [4];
    logic signed [17:0] Xi0 [4];
    logic signed [15:0] Xr1 [4];
    logic signed [15:0] Xi1 [4];

    frame_t q0[$];
    frame_t q1[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft4_cplx_stream #(.WIDTH(16), .SCALE(0)) u_s0 (
        .clk(clk), .reset(reset_n),
        .in_valid(iv0), .in_ready(rdy0),
        .x0_re(xr0[0]), .x1_re(xr0[1]), .x2_re(xr0[2]), .x3_re(xr0[3]),
        .x0_im(xi0[0]), .x1_im(xi0[1]), .x2_im(xi0[2]), .x3_im(xi0[3]),
        .out_valid(ov0), .out_ready(ordy0),
        .X0_re(Xr0[0]), .X1_re(Xr0[1]), .X2_re(Xr0[2]), .X3_re(Xr0[3]),
        .X0_im(Xi0[0]), .X1_im(Xi0[1]), .X2_im(Xi0[2]), .X3_im(Xi0[3]),
        .busy(busy0)
    );

    fft4_cplx_stream #(.WIDTH(16), .SCALE(1)) u_s1 (
        .clk(clk), .reset(reset_n),
        .in_valid(iv1), .in_ready(rdy1),
        .x0_re(xr1[0]), .x1_re(xr1[1]), .x2_re(xr1[2]), .x3_re(xr1[3]),
        .x0_im(xi1[0]), .x1_im(xi1[1]), .x2_im(xi1[2]), .x3_im(xi1[3]),
        .out_valid(ov1), .out_ready(ordy1),
        .X0_re(Xr1[0]), .X1_re(Xr1[1]), .X2_re(Xr1[2]), .X3_re(Xr1[3]),
        .X0_im(Xi1[0]), .X1_im(Xi1[1]), .X2_im(Xi1[2]), .X3_im(Xi1[3]),
        .busy(busy1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input int r[4], input int i[4]);
        frame_t f;
        f.re = r;
        f.im = i;
        if (sel == 0) q0.push_back(f);
        else          q1.push_back(f);
    endtask

    task automatic drive(input int sel, input int r[4], input int i[4]);
        for (int k = 0; k < 4; k++) begin
            if (sel == 0) begin
                xr0[k] = 16'(r[k]);
                xi0[k] = 16'(i[k]);
            end else begin
                xr1[k] = 16'(r[k]);
                xi1[k] = 16'(i[k]);
            end
        end
    endtask

    // Returns just after the accepting edge.
    task automatic send(input int sel, input int r[4], input int i[4]);
        int t;
        t = 0;
        while (!(sel == 0 ? rdy0 : rdy1) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("accept_timeout", 0, 1);
        drive(sel, r, i);
        if (sel == 0) iv0 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic wait_ov(input int sel);
        int t;
        t = 0;
        while (!(sel == 0 ? ov0 : ov1) && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) chk("out_valid_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (reset_n && ov0 && ordy0) begin
            if (q0.size() == 0) chk("s0_unexpected_frame", 1, 0);
            else begin
                frame_t e;
                e = q0.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("s0_X%0d_re", k), int'(Xr0[k]), e.re[k]);
                    chk($sformatf("s0_X%0d_im", k), int'(Xi0[k]), e.im[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && ov1 && ordy1) begin
            if (q1.size() == 0) chk("s1_unexpected_frame", 1, 0);
            else begin
                frame_t e;
                e = q1.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("s1_X%0d_re", k), int'(Xr1[k]), e.re[k]);
                    chk($sformatf("s1_X%0d_im", k), int'(Xi1[k]), e.im[k]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        drive(0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        drive(1, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        #12;
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_in_ready", int'(rdy0), 1);
        chk("rst_X0_re", int'(Xr0[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // DC frame, unscaled, with latency check
        push(0, '{16, 0, 0, 0}, '{0, 0, 0, 0});
        send(0, '{4, 4, 4, 4}, '{0, 0, 0, 0});
        chk("lat_busy", int'(busy0), 1);
        chk("lat_ov_c1", int'(ov0), 0);
        @(posedge clk); #1;
        chk("lat_ov_c2", int'(ov0), 0);
        @(posedge clk); #1;
        chk("lat_ov_c3", int'(ov0), 1);
        @(posedge clk); #1;

        // general complex frame, unscaled
        push(0, '{7, -2, -9, 8}, '{5, 4, -1, 0});
        send(0, '{1, 3, -2, 5}, '{2, -1, 0, 4});
        wait_ov(0);
        @(posedge clk); #1;

        // odd-real frame, unscaled
        push(0, '{0, 0, 0, 0}, '{0, -2, 0, 2});
        send(0, '{0, 1, 0, -1}, '{0, 0, 0, 0});
        wait_ov(0);
        @(posedge clk); #1;

        // most-negative inputs, unscaled: must grow without wrap
        push(0, '{-131072, 0, 0, 0}, '{-131072, 0, 0, 0});
        send(0, '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768});
        wait_ov(0);
        @(posedge clk); #1;

        // reset in the middle of S2 discards the frame and clears the outputs
        send(0, '{1, 2, 3, 4}, '{5, 6, 7, 8});
        @(posedge clk); #1;
        chk("midrst_busy_before", int'(busy0), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(ov0), 0);
        chk("midrst_X0_re", int'(Xr0[0]), 0);
        chk("midrst_X0_im", int'(Xi0[0]), 0);
        chk("midrst_busy", int'(busy0), 0);
        #1;
        reset_n = 1'b1;
        chk("midrst_in_ready", int'(rdy0), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_frame", int'(ov0), 0);

        // scaled: mixed-sign complex frame
        push(1, '{4, 4, 4, -4}, '{0, 0, 0, 0});
        send(1, '{8, 0, 8, 0}, '{0, 8, 0, -8});
        wait_ov(1);
        @(posedge clk); #1;

        // scaled: most-negative inputs stay in range
        push(1, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0});
        send(1, '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768});
        wait_ov(1);
        @(posedge clk); #1;

        // scaled impulse held under back-pressure, new frame offered meanwhile
        ordy1 = 1'b0;
        push(1, '{1, 1, 1, 1}, '{0, 0, 0, 0});
        send(1, '{4, 0, 0, 0}, '{0, 0, 0, 0});
        wait_ov(1);
        for (int c = 0; c < 5; c++) begin
            drive(1, '{-1, 0, 0, 0}, '{0, 0, 0, 0});
            iv1 = 1'b1;
            @(posedge clk); #1;
            chk("hold_out_valid", int'(ov1), 1);
            chk("hold_in_ready", int'(rdy1), 0);
            chk("hold_X0_re", int'(Xr1[0]), 1);
            chk("hold_X3_re", int'(Xr1[3]), 1);
            chk("hold_X1_im", int'(Xi1[1]), 0);
        end
        push(1, '{-1, -1, -1, -1}, '{0, 0, 0, 0});
        ordy1 = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", int'(rdy1), 1);
        chk("release_out_valid", int'(ov1), 0);
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("next_accept_busy", int'(busy1), 1);
        wait_ov(1);

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
